// File: rtl/ctrl_seq_pkg.sv
// Shared types and helpers for the ctrl_sequencer instruction sequencer.
// Opcode class encodings and IR field offsets are derived from the configured widths.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALTED    = 3'd4,
    ST_PAUSE     = 3'd5
  } ctrl_state_e;

  function automatic int opc_halt(input int opc_w);
    return (1 << opc_w) - 1;
  endfunction

  function automatic int opc_jz(input int opc_w);
    return (1 << opc_w) - 2;
  endfunction

  // LSB positions of the opcode and register fields within IR
  function automatic int opc_lsb(input int instr_w, input int opc_w);
    return instr_w - opc_w;
  endfunction

  function automatic int reg_lsb(input int instr_w, input int opc_w, input int rf_addr_w);
    return instr_w - opc_w - rf_addr_w;
  endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational IR field extraction and opcode classification for ctrl_sequencer.
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int OPC_W     = 3,
  parameter int RF_ADDR_W = 2,
  parameter int PC_W      = 8
) (
  input  logic [INSTR_W-1:0]   ir,
  output logic [OPC_W-1:0]     opcode,
  output logic [RF_ADDR_W-1:0] rf_reg,
  output logic [PC_W-1:0]      target,
  output logic                 is_halt,
  output logic                 is_jz,
  output logic                 is_alu
);

  localparam int OPC_LSB = opc_lsb(INSTR_W, OPC_W);
  localparam int REG_LSB = reg_lsb(INSTR_W, OPC_W, RF_ADDR_W);
  localparam logic [OPC_W-1:0] OPC_HALT = OPC_W'(opc_halt(OPC_W));
  localparam logic [OPC_W-1:0] OPC_JZ   = OPC_W'(opc_jz(OPC_W));

  assign opcode  = ir[OPC_LSB +: OPC_W];
  assign rf_reg  = ir[REG_LSB +: RF_ADDR_W];
  assign target  = ir[PC_W-1:0];

  assign is_halt = (opcode == OPC_HALT);
  assign is_jz   = (opcode == OPC_JZ);
  assign is_alu  = !is_halt && !is_jz;

  // Bits between the register and target fields carry no meaning
  logic unused_ir;
  assign unused_ir = ^ir;

endmodule

// File: rtl/ctrl_sequencer.sv
// Four-phase instruction sequencer: fetch handshake, IR, program counter, JZ and HALT.
// Optional CTRL_SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state after each instruction.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int OPC_W     = 3,
  parameter int RF_ADDR_W = 2,
  parameter int PC_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CTRL_SEQ_SINGLE_STEP_EN
  input  logic                 step,
`endif
  output logic                 instr_req,
  output logic [PC_W-1:0]      instr_addr,
  input  logic                 instr_valid,
  input  logic [INSTR_W-1:0]   instr_data,
  input  logic                 alu_zero,
  output logic [INSTR_W-1:0]   instruction_wire,
  output logic                 A_ce,
  output logic                 ALU_ce,
  output logic [OPC_W-1:0]     ALU_opcode_wire,
  output logic [RF_ADDR_W-1:0] RF_addr,
  output logic                 RF_we,
  output logic [PC_W-1:0]      pc,
  output logic                 halted
);

  localparam logic [2:0] S_FETCH     = ST_FETCH;
  localparam logic [2:0] S_DECODE    = ST_DECODE;
  localparam logic [2:0] S_EXECUTE   = ST_EXECUTE;
  localparam logic [2:0] S_WRITEBACK = ST_WRITEBACK;
  localparam logic [2:0] S_HALTED    = ST_HALTED;
`ifdef CTRL_SEQ_SINGLE_STEP_EN
  localparam logic [2:0] S_PAUSE     = ST_PAUSE;
  localparam logic [2:0] S_AFTER_OP  = ST_PAUSE;
`else
  localparam logic [2:0] S_AFTER_OP  = ST_FETCH;
`endif

  logic [2:0]           state;
  logic [INSTR_W-1:0]   ir;
  logic [PC_W-1:0]      pc_q;
  logic                 run_q;
  logic                 out_en;

  logic [OPC_W-1:0]     opcode;
  logic [RF_ADDR_W-1:0] rf_reg;
  logic [PC_W-1:0]      target;
  logic                 is_halt;
  logic                 is_jz;
  logic                 is_alu;

  ctrl_seq_decode #(
    .INSTR_W  (INSTR_W),
    .OPC_W    (OPC_W),
    .RF_ADDR_W(RF_ADDR_W),
    .PC_W     (PC_W)
  ) u_decode (
    .ir     (ir),
    .opcode (opcode),
    .rf_reg (rf_reg),
    .target (target),
    .is_halt(is_halt),
    .is_jz  (is_jz),
    .is_alu (is_alu)
  );

  // run_q holds the FSM (and all outputs) quiet for the first cycle after reset releases
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
      pc_q  <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        case (state)
          S_FETCH: begin
            if (instr_valid) begin
              ir    <= instr_data;
              state <= S_DECODE;
            end
          end
          S_DECODE: begin
            if (is_halt) begin
              state <= S_HALTED;
            end else if (is_jz) begin
              pc_q  <= alu_zero ? target : pc_q + PC_W'(1);
              state <= S_AFTER_OP;
            end else begin
              state <= S_EXECUTE;
            end
          end
          S_EXECUTE:   state <= S_WRITEBACK;
          S_WRITEBACK: begin
            pc_q  <= pc_q + PC_W'(1);
            state <= S_AFTER_OP;
          end
`ifdef CTRL_SEQ_SINGLE_STEP_EN
          S_PAUSE: begin
            if (step) state <= S_FETCH;
          end
`endif
          S_HALTED:    state <= S_HALTED;
          default:     state <= S_FETCH;
        endcase
      end
    end
  end

  assign out_en = run_q && !rst;

  always_comb begin
    instr_req       = 1'b0;
    A_ce            = 1'b0;
    ALU_ce          = 1'b0;
    ALU_opcode_wire = '0;
    RF_addr         = '0;
    RF_we           = 1'b0;
    halted          = 1'b0;
    if (out_en) begin
      case (state)
        S_FETCH:  instr_req = 1'b1;
        S_DECODE: begin
          RF_addr = rf_reg;
          A_ce    = is_alu;
        end
        S_EXECUTE: begin
          ALU_ce          = 1'b1;
          ALU_opcode_wire = opcode;
          RF_addr         = rf_reg;
        end
        S_WRITEBACK: begin
          RF_we   = 1'b1;
          RF_addr = rf_reg;
        end
        S_HALTED: halted = 1'b1;
        default:  ;
      endcase
    end
  end

  assign pc               = out_en ? pc_q : '0;
  assign instr_addr       = pc;
  assign instruction_wire = out_en ? ir : '0;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized scoreboard bench for ctrl_sequencer (default widths).
`timescale 1ns/1ps
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = '0;
  logic        alu_zero = 1'b0;
`ifdef CTRL_SEQ_SINGLE_STEP_EN
  logic        step = 1'b1;
  localparam int STEP_EXTRA = 1;
`else
  localparam int STEP_EXTRA = 0;
`endif

  logic        instr_req;
  logic [7:0]  instr_addr;
  logic [15:0] instruction_wire;
  logic        A_ce, ALU_ce, RF_we, halted;
  logic [2:0]  ALU_opcode_wire;
  logic [1:0]  RF_addr;
  logic [7:0]  pc;

  ctrl_sequencer dut (
    .clk             (clk),
    .rst             (rst),
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    .step            (step),
`endif
    .instr_req       (instr_req),
    .instr_addr      (instr_addr),
    .instr_valid     (instr_valid),
    .instr_data      (instr_data),
    .alu_zero        (alu_zero),
    .instruction_wire(instruction_wire),
    .A_ce            (A_ce),
    .ALU_ce          (ALU_ce),
    .ALU_opcode_wire (ALU_opcode_wire),
    .RF_addr         (RF_addr),
    .RF_we           (RF_we),
    .pc              (pc),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] opc;
    logic [1:0] rg;
  } op_t;

  logic [7:0] fetch_q[$];
  op_t        op_q[$];
  bit         pend = 1'b0;
  op_t        pend_op;
  int         a_cyc = 0;
  logic [7:0] model_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against queued expectations
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_req && instr_valid) begin
        if (fetch_q.size() == 0) chk("unexpected_fetch", 1, 0);
        else chk("fetch_addr", instr_addr, fetch_q.pop_front());
      end
      if (instr_req) chk("fetch_quiet_outs", {RF_addr, ALU_opcode_wire, A_ce, ALU_ce, RF_we, halted}, 0);
      if (A_ce) begin
        if (op_q.size() == 0) chk("unexpected_A_ce", 1, 0);
        else begin
          pend_op = op_q.pop_front();
          pend    = 1'b1;
          a_cyc   = cyc;
          chk("decode_rf_addr", RF_addr, pend_op.rg);
        end
      end
      if (ALU_ce) begin
        if (!pend) chk("unexpected_ALU_ce", 1, 0);
        else begin
          chk("alu_ce_delay", cyc - a_cyc, 1);
          chk("alu_opcode", ALU_opcode_wire, pend_op.opc);
          chk("exec_rf_addr", RF_addr, pend_op.rg);
        end
      end else begin
        chk("alu_opcode_idle", ALU_opcode_wire, 0);
      end
      if (RF_we) begin
        if (!pend) chk("unexpected_RF_we", 1, 0);
        else begin
          chk("rf_we_delay", cyc - a_cyc, 2);
          chk("wb_rf_addr", RF_addr, pend_op.rg);
          pend = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    instr_valid = 1'b0;
    pend = 1'b0;
    fetch_q.delete();
    op_q.delete();
    tick();
    chk("rst_outputs", {instr_req, A_ce, ALU_ce, RF_we, halted, RF_addr, ALU_opcode_wire}, 0);
    chk("rst_pc", {instr_addr, pc}, 0);
    chk("rst_ir", instruction_wire, 0);
    repeat (n - 1) tick();
    rst = 1'b0;
    model_pc = '0;
    chk("req_low_release_cycle", instr_req, 0);
    tick();
    chk("req_rises", instr_req, 1);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (instr_req) ok = 1'b1;
      else tick();
    end
    if (!ok) chk("wait_req_timeout", 0, 1);
  endtask

  task automatic serve(input logic [15:0] w, input int waits, input bit zero);
    bit ok;
    int t0, lat;
    logic [2:0] opc;
    opc = w[15:13];
    wait_req(ok);
    if (!ok) return;
    t0 = cyc;
    for (int i = 0; i < waits; i++) begin
      instr_valid = 1'b0;
      instr_data  = 16'($urandom);
      tick();
      chk("wait_req_held", {instr_req, instr_addr}, {1'b1, model_pc});
    end
    instr_valid = 1'b1;
    instr_data  = w;
    alu_zero    = zero;
    fetch_q.push_back(model_pc);
    if (opc == 3'd7) lat = 2;
    else if (opc == 3'd6) begin
      lat = 2 + STEP_EXTRA;
      model_pc = zero ? w[7:0] : model_pc + 8'd1;
    end else begin
      lat = 4 + STEP_EXTRA;
      op_q.push_back({opc, w[12:11]});
      model_pc = model_pc + 8'd1;
    end
    tick();
    instr_valid = 1'b0;
    instr_data  = 16'($urandom);
    chk("ir_latched", instruction_wire, w);
    tick();
    alu_zero = 1'($urandom);
    if (opc == 3'd7) begin
      chk("halted_state", {halted, instr_req}, 2'b10);
      return;
    end
    wait_req(ok);
    if (ok) begin
      chk("instr_latency", cyc - t0, waits + lat);
      chk("pc_after", {pc, instr_addr}, {model_pc, model_pc});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [2:0] ropc;
    logic [15:0] rw;

    do_reset(2);
    serve(16'h2800, 0, 1'b0);          // ALU op 001, reg 1
    serve(16'h5000, 3, 1'b0);          // three fetch wait states
    serve(16'hC005, 0, 1'b1);          // JZ taken
    serve(16'hC005, 0, 1'b0);          // JZ not taken
    serve({8'hC0, model_pc}, 1, 1'b1); // spin loop on itself

    for (int i = 0; i < 40; i++) begin
      ropc = 3'($urandom_range(0, 6));
      rw   = {ropc, 13'($urandom)};
      serve(rw, int'($urandom_range(0, 3)), 1'($urandom));
    end

    serve(16'hC0FF, 0, 1'b1);          // jump to 255
    serve(16'h1800, 2, 1'b0);          // pc wraps to 0
    serve(16'hA000, 0, 1'b0);

    // Reset during EXECUTE must abort without a writeback pulse
    wait_req(ok);
    instr_valid = 1'b1;
    instr_data  = 16'h3800;
    fetch_q.push_back(model_pc);
    op_q.push_back({3'd1, 2'd3});
    tick();
    instr_valid = 1'b0;
    tick();
    chk("mid_op_in_execute", ALU_ce, 1);
    do_reset(1);
    repeat (3) tick();
    serve(16'h0800, 0, 1'b0);

    // HALT then reset
    serve(16'hE000, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold", {halted, instr_req, A_ce, ALU_ce, RF_we}, 5'b10000);
    end
    do_reset(2);
    chk("pc_after_halt_reset", pc, 0);
    serve(16'h4000, 0, 1'b0);

`ifdef CTRL_SEQ_SINGLE_STEP_EN
    step = 1'b0;
    wait_req(ok);
    instr_valid = 1'b1;
    instr_data  = 16'h2800;
    fetch_q.push_back(model_pc);
    op_q.push_back({3'd1, 2'd1});
    model_pc = model_pc + 8'd1;
    tick();
    instr_valid = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      chk("pause_idle", {instr_req, A_ce, ALU_ce, RF_we}, 0);
      tick();
    end
    step = 1'b1;
    chk("pause_before_step", instr_req, 0);
    tick();
    chk("fetch_after_step", {instr_req, pc}, {1'b1, model_pc});
`endif

    repeat (3) tick();
    chk("queues_drained", fetch_q.size() + op_q.size() + int'(pend), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised multi-cycle instruction sequencer that replaces the fixed 16-bit simple control path inside `simple_top`. It fetches instruction words from program memory over a request/valid handshake and latches each one. It then steps a four-phase FSM (FETCH, DECODE, EXECUTE, WRITEBACK) that drives the accumulator, ALU and register-file enables. Beyond the existing fixed sequence, it adds configurable widths, a fetch wait-state handshake, a conditional jump and a halt state.

## Interface
- `INSTR_W`, 16, instruction word width.
- `OPC_W`, 3, opcode field width; also the width of `ALU_opcode_wire`.
- `RF_ADDR_W`, 2, register-file address width.
- `PC_W`, 8, program-counter width. Constraint: `OPC_W+RF_ADDR_W+PC_W <= INSTR_W`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `instr_req`  out  1  fetch request.
- `instr_addr`  out  PC_W  fetch address; equals `pc`.
- `instr_valid`  in  1  `instr_data` is valid this cycle.
- `instr_data`  in  INSTR_W  fetched word.
- `alu_zero`  in  1  ALU zero flag, sampled in DECODE of JZ.
- `instruction_wire`  out  INSTR_W  latched instruction register (IR).
- `A_ce`  out  1  accumulator operand load enable.
- `ALU_ce`  out  1  ALU enable.
- `ALU_opcode_wire`  out  OPC_W  ALU operation.
- `RF_addr`  out  RF_ADDR_W  register-file address.
- `RF_we`  out  1  register-file write enable.
- `pc`  out  PC_W  program counter.
- `halted`  out  1  high while in HALTED.

## Operation
Field layout of IR:
- opcode `[INSTR_W-1 -: OPC_W]`
- register `[INSTR_W-OPC_W-1 -: RF_ADDR_W]`
- target `[PC_W-1:0]`

Opcode classes:
- All-ones opcode is HALT.
- All-ones minus one is JZ.
- Every other value is an ALU op, passed straight through to `ALU_opcode_wire`.

States, with outputs decoded from state and IR:
- FETCH: `instr_req=1`. Waits any number of cycles for `instr_valid`. On valid, IR <= `instr_data` and the FSM goes to DECODE. `instr_data` is ignored while `instr_valid=0`.
- DECODE: `RF_addr`=IR register field.
  - ALU op: `A_ce=1`, next state EXECUTE.
  - JZ: no enables. `pc` <= target if `alu_zero`, else `pc+1`. Next state FETCH.
  - HALT: next state HALTED; `pc` holds.
- EXECUTE: `ALU_ce=1`, `ALU_opcode_wire`=opcode, `RF_addr` held. Next state WRITEBACK.
- WRITEBACK: `RF_we=1`, `RF_addr` held, `pc` <= `pc+1`. Next state FETCH.
- HALTED: all enables 0, `halted=1`. Stays here until `rst`.

Rules:
- `ALU_opcode_wire` is 0 outside EXECUTE.
- `RF_addr` is 0 in FETCH and HALTED.
- `pc` arithmetic is modulo 2^PC_W: `pc+1` wraps from all-ones to 0.
- A JZ target equal to `pc` is legal and produces a spin loop.

## Timing
- While `rst`=1 and in the cycle it is sampled:
  - state <= FETCH, `pc`=0, IR=0.
  - Every output is 0, including `instr_req`.
- `instr_req` rises in the first cycle after `rst` is sampled low.
- A reset asserted mid-fetch or mid-instruction aborts that instruction. No `RF_we` pulse follows the reset.
- With zero fetch wait states:
  - An ALU instruction takes 4 cycles.
  - JZ takes 2 cycles.
  - HALT takes 2 cycles to reach HALTED.
- Each fetch wait cycle adds 1 cycle.
- `A_ce`, `ALU_ce` and `RF_we` are single-cycle pulses in consecutive cycles D, D+1 and D+2.
- `pc` updates at the end of WRITEBACK or JZ-DECODE; the new address is visible in the next FETCH cycle.
- `alu_zero` is sampled only in the DECODE cycle of JZ.

## Configuration
- `CTRL_SEQ_SINGLE_STEP_EN` defined: adds input port `step` (1 bit) and state PAUSE.
  - WRITEBACK and JZ-DECODE go to PAUSE instead of FETCH.
  - PAUSE drives all enables to 0 and moves to FETCH in the cycle after `step` is sampled 1.
  - `rst` in PAUSE behaves as normal reset.
- Undefined: no `step` port and no PAUSE state; behaviour is exactly as specified above.

## Structure
- Package `ctrl_seq_pkg`:
  - state enum `ctrl_state_e`.
  - functions `opc_halt(OPC_W)` and `opc_jz(OPC_W)`, returning all-ones and all-ones minus one.
  - field-offset localparam helpers.
- Sub-module `ctrl_seq_decode`: purely combinational extraction of opcode, register and target fields and of the class flags (`is_halt`, `is_jz`, `is_alu`) from IR. It is parametrised the same way as the top.
- `ctrl_sequencer` contains the FSM, IR, `pc` and output decode.

## Test plan
Default parameters apply unless noted.
1. Reset then ALU op: hold `rst` for 2 cycles; serve 16'h2800 with zero wait.
   - `instr_req` rises 1 cycle after reset.
   - `A_ce`, `ALU_ce` (opcode 3'b001) and `RF_we` each pulse once, in successive cycles, with `RF_addr`=1.
   - `pc` goes 0 -> 1.
2. Fetch wait states: delay `instr_valid` 3 cycles.
   - `instr_req` stays 1 with `instr_addr`=0 throughout.
   - The instruction completes in 7 cycles.
   - Garbage on `instr_data` while `instr_valid=0` is not latched.
3. JZ taken and not taken: serve 16'hC005.
   - With `alu_zero=1`: `pc` becomes 5 and `ALU_ce`/`RF_we` never pulse.
   - With `alu_zero=0`: `pc` becomes 1.
4. HALT: serve 16'hE000.
   - `halted=1` 2 cycles after valid.
   - `instr_req` stays 0 for 20 further cycles.
   - `rst` returns to FETCH with `pc`=0.
5. Wrap and mid-op reset:
   - Run ALU ops starting from `pc`=255; `pc` wraps to 0.
   - Assert `rst` during EXECUTE: no `RF_we` pulse, all outputs 0 the next cycle.
6. Single step (`CTRL_SEQ_SINGLE_STEP_EN` defined):
   - After WRITEBACK the FSM idles with `instr_req=0` until `step`=1.
   - FETCH follows exactly 1 cycle later.
